// File: rtl/imem_loadable.sv
// Writable instruction RAM: registered 1-cycle fetch port plus a byte-serial valid/ready load port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module imem_loadable #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              rd_en,
    output logic [DATA_W-1:0] op,
    output logic              op_valid,
    input  logic              ld_start,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic              parity_err
);
    localparam int BPW   = DATA_W / 8;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ASM_W = (DATA_W > 8) ? DATA_W - 8 : 1;
    localparam int AW1   = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_C = AW1'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = AW1'(DEPTH - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPW - 1);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {RUN, LOAD} state_t;

    state_t            state_q, state_d;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] waddr_q;
    logic [BC_W-1:0]   bcnt_q;
    logic [ASM_W-1:0]  asm_q;
    logic [DATA_W-1:0] word;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rword;
    logic              accept, word_done, last_word, fetch, in_range;

    // Big-endian assembly: earlier bytes shift toward the MSBs as later bytes arrive.
    if (DATA_W > 8) begin : g_shift
        assign word = {asm_q[DATA_W-9:0], ld_data};
    end else begin : g_byte
        assign word = ld_data;
    end

    assign rword     = mem[pc[IDX_W-1:0]];
    assign in_range  = {1'b0, pc} < DEPTH_C;
    assign last_word = {1'b0, waddr_q} == LAST_C;

    always_comb begin
        state_d   = state_q;
        ld_busy   = 1'b0;
        ld_ready  = 1'b0;
        accept    = 1'b0;
        word_done = 1'b0;
        fetch     = 1'b0;
        case (state_q)
            RUN: begin
                fetch = rd_en && !ld_start;
                if (ld_start) state_d = LOAD;
            end
            LOAD: begin
                ld_busy   = 1'b1;
                ld_ready  = !ld_start;
                accept    = ld_valid && !ld_start;
                word_done = accept && (bcnt_q == BC_LAST);
                if (ld_start || (word_done && last_word)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            waddr_q  <= '0;
            bcnt_q   <= '0;
            asm_q    <= '0;
            ld_done  <= 1'b0;
            ld_count <= '0;
            op       <= '0;
            op_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_valid <= fetch;
            if (fetch) op <= in_range ? rword[DATA_W-1:0] : '0;
            if (state_q == RUN && ld_start) begin
                waddr_q  <= '0;
                bcnt_q   <= '0;
                asm_q    <= '0;
                ld_count <= '0;
            end else if (word_done) begin
                waddr_q  <= waddr_q + 1'b1;
                ld_count <= ld_count + 1'b1;
                bcnt_q   <= '0;
            end else if (accept) begin
                bcnt_q <= bcnt_q + 1'b1;
                asm_q  <= word[ASM_W-1:0];
            end
            if (state_q == LOAD && state_d == RUN) ld_done <= 1'b1;
        end
    end

`ifdef IMEM_PARITY_EN
    assign wr_word = {^word, word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= fetch && in_range && ((^rword[DATA_W-1:0]) != rword[DATA_W]);
        end
    end
`else
    assign wr_word    = word;
    assign parity_err = 1'b0;
`endif

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (word_done) mem[waddr_q[IDX_W-1:0]] <= wr_word;
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: two instances (DEPTH 256 and 200) share stimulus and are checked against a word-level model.
`timescale 1ns/1ps
module tb_imem_loadable;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] pc;
    logic       rd_en, ld_start, ld_valid;
    logic [7:0] ld_data;

    logic [15:0] op_a, op_b;
    logic        ov_a, ov_b, rdy_a, rdy_b, busy_a, busy_b, done_a, done_b, pe_a, pe_b;
    logic [8:0]  cnt_a, cnt_b;

    imem_loadable #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .pc(pc), .rd_en(rd_en), .op(op_a), .op_valid(ov_a),
        .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(rdy_a),
        .ld_busy(busy_a), .ld_done(done_a), .ld_count(cnt_a), .parity_err(pe_a));

    imem_loadable #(.ADDR_W(8), .DATA_W(16), .DEPTH(200)) dut_b (
        .clk(clk), .rst_n(rst_n), .pc(pc), .rd_en(rd_en), .op(op_b), .op_valid(ov_b),
        .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(rdy_b),
        .ld_busy(busy_b), .ld_done(done_b), .ld_count(cnt_b), .parity_err(pe_b));

    int checks = 0;
    int errors = 0;

    // Word-level model: a load is a list of byte pairs; word n of the load lands at address n.
    int unsigned m_depth [2] = '{256, 200};
    bit          m_load [2];
    bit          m_done [2];
    bit          m_have_first [2];
    bit          m_ov [2];
    bit          m_pe [2];
    bit          m_op_known [2];
    int unsigned m_cnt [2];
    logic [7:0]  m_first [2];
    logic [15:0] m_op [2];
    logic [15:0] m_mem [2][256];
    bit          m_known [2][256];
    bit          m_flip [2][256];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_load[i] = 0; m_done[i] = 0; m_have_first[i] = 0;
            m_ov[i] = 0; m_pe[i] = 0; m_op_known[i] = 1;
            m_cnt[i] = 0; m_first[i] = '0; m_op[i] = '0;
            for (int a = 0; a < 256; a++) begin
                m_known[i][a] = 0;
                m_flip[i][a]  = 0;
            end
        end
    endfunction

    function automatic void model_step(int i);
        m_ov[i] = 0;
        m_pe[i] = 0;
        if (!m_load[i]) begin
            if (ld_start) begin
                m_load[i] = 1; m_cnt[i] = 0; m_have_first[i] = 0;
            end else if (rd_en) begin
                m_ov[i] = 1;
                if (pc < m_depth[i]) begin
                    m_op[i] = m_mem[i][pc];
                    m_op_known[i] = m_known[i][pc];
                    m_pe[i] = m_flip[i][pc];
                end else begin
                    m_op[i] = '0;
                    m_op_known[i] = 1;
                end
            end
        end else if (ld_start) begin
            m_load[i] = 0; m_done[i] = 1;
        end else if (ld_valid) begin
            if (!m_have_first[i]) begin
                m_first[i] = ld_data;
                m_have_first[i] = 1;
            end else begin
                m_mem[i][m_cnt[i]]   = {m_first[i], ld_data};
                m_known[i][m_cnt[i]] = 1;
                m_flip[i][m_cnt[i]]  = 0;
                m_have_first[i] = 0;
                m_cnt[i]++;
                if (m_cnt[i] == m_depth[i]) begin
                    m_load[i] = 0; m_done[i] = 1;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input logic [15:0] op, input logic ov, input logic rdy,
                            input logic busy, input logic done, input logic pe, input logic [8:0] cnt);
        chk($sformatf("op_valid[%0d]", i), 32'(ov), 32'(m_ov[i]));
        chk($sformatf("ld_busy[%0d]", i), 32'(busy), 32'(m_load[i]));
        chk($sformatf("ld_ready[%0d]", i), 32'(rdy), 32'(m_load[i] && !ld_start));
        chk($sformatf("ld_done[%0d]", i), 32'(done), 32'(m_done[i]));
        chk($sformatf("ld_count[%0d]", i), 32'(cnt), m_cnt[i]);
        chk($sformatf("parity_err[%0d]", i), 32'(pe), 32'(m_pe[i]));
        if (m_op_known[i]) chk($sformatf("op[%0d]", i), 32'(op), 32'(m_op[i]));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp_inst(0, op_a, ov_a, rdy_a, busy_a, done_a, pe_a, cnt_a);
            cmp_inst(1, op_b, ov_b, rdy_b, busy_b, done_b, pe_b, cnt_b);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1; cyc(); ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                ld_valid = 1'b0; ld_data = 8'($urandom);
                rd_en = 1'($urandom); pc = 8'($urandom);
                cyc();
            end
        end
        rd_en = 1'b0; ld_valid = 1'b1; ld_data = b;
        cyc();
        ld_valid = 1'b0;
    endtask

    task automatic read(input logic [7:0] p);
        rd_en = 1'b1; pc = p; cyc(); rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic full_load_pattern();
        pulse_start();
        for (int k = 0; k < 256; k++) begin
            send_byte(8'(k), 1'b0);
            send_byte(8'(k), 1'b0);
        end
        @(negedge clk);
        chk("full busy", 32'(busy_a), 32'd0);
        chk("full done", 32'(done_a), 32'd1);
        chk("full count", 32'(cnt_a), 32'd256);
        chk("full count200", 32'(cnt_b), 32'd200);
        read(8'd0);   chk("rd0", 32'(op_a), 32'h0000); chk("rd0 valid", 32'(ov_a), 32'd1);
        read(8'd1);   chk("rd1", 32'(op_a), 32'h0101);
        read(8'd255); chk("rd255", 32'(op_a), 32'hFFFF);
    endtask

    task automatic do_reset();
        cyc(); #2 rst_n = 1'b0;
        cyc(); #2 rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pc = '0; rd_en = 1'b0; ld_start = 1'b0; ld_data = '0; ld_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset op", 32'(op_a), 32'd0);
        chk("reset op_valid", 32'(ov_a), 32'd0);
        chk("reset ready", 32'(rdy_a), 32'd0);
        chk("reset busy", 32'(busy_a), 32'd0);
        chk("reset done", 32'(done_a), 32'd0);
        chk("reset count", 32'(cnt_a), 32'd0);
        #2 rst_n = 1'b1;

        full_load_pattern();
        read(8'd250); chk("oor op", 32'(op_b), 32'd0); chk("oor valid", 32'(ov_b), 32'd1);
        read(8'd199); chk("b rd199", 32'(op_b), 32'hC7C7);

        // Back-to-back fetches, one per cycle.
        for (int k = 0; k < 40; k++) begin
            rd_en = 1'b1; pc = 8'($urandom); cyc();
        end
        rd_en = 1'b0;

        // Early terminate: partial third byte is dropped.
        pulse_start();
        send_byte(8'hA1, 1'b0); send_byte(8'hB2, 1'b0); send_byte(8'hC3, 1'b0);
        pulse_start();
        @(negedge clk);
        chk("early count", 32'(cnt_a), 32'd1);
        chk("early busy", 32'(busy_a), 32'd0);
        read(8'd0); chk("early rd0", 32'(op_a), 32'hA1B2);
        read(8'd1); chk("early rd1", 32'(op_a), 32'h0101);

        // Gapped load of random words with stray fetch requests while loading.
        pulse_start();
        for (int k = 0; k < 256; k++) begin
            send_byte(8'($urandom), 1'b1);
            send_byte(8'($urandom), 1'b1);
        end
        rd_en = 1'b0;
        for (int k = 0; k < 256; k++) begin
            rd_en = 1'b1; pc = 8'(k); cyc();
        end
        rd_en = 1'b0;

        // Fetch colliding with ld_start loses.
        rd_en = 1'b1; pc = 8'd3; ld_start = 1'b1; cyc();
        rd_en = 1'b0; ld_start = 1'b0;
        @(negedge clk);
        chk("conflict valid", 32'(ov_a), 32'd0);
        chk("conflict busy", 32'(busy_a), 32'd1);
        pulse_start();
        @(negedge clk);
        chk("empty load count", 32'(cnt_a), 32'd0);

        // Random mix of everything.
        for (int k = 0; k < 1500; k++) begin
            ld_start = ($urandom_range(0, 39) == 0);
            ld_valid = 1'($urandom); ld_data = 8'($urandom);
            rd_en = 1'($urandom); pc = 8'($urandom);
            cyc();
        end
        ld_start = 1'b0; ld_valid = 1'b0; rd_en = 1'b0;
        do_reset();

        // Reset mid-load, asynchronous.
        pulse_start();
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst op", 32'(op_a), 32'd0);
        chk("midrst valid", 32'(ov_a), 32'd0);
        chk("midrst busy", 32'(busy_a), 32'd0);
        chk("midrst ready", 32'(rdy_a), 32'd0);
        chk("midrst done", 32'(done_a), 32'd0);
        chk("midrst count", 32'(cnt_a), 32'd0);
        chk("midrst parity", 32'(pe_a), 32'd0);
        cyc(); #2 rst_n = 1'b1;
        full_load_pattern();

`ifdef IMEM_PARITY_EN
        dut_a.mem[5][0] = ~dut_a.mem[5][0];
        m_mem[0][5][0] = ~m_mem[0][5][0];
        m_flip[0][5] = 1;
        read(8'd5); chk("parity flagged", 32'(pe_a), 32'd1); chk("parity valid", 32'(ov_a), 32'd1);
        cyc();
        @(negedge clk);
        chk("parity one cycle", 32'(pe_a), 32'd0);
        read(8'd6); chk("parity clean", 32'(pe_a), 32'd0);
`endif

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, writable instruction memory for the four-colour CPU. It replaces a fixed, combinational program ROM with a synchronous-read RAM. A byte-serial load port with a valid/ready handshake fills the RAM at run time, so programs change without re-synthesis. It sits between the fetch stage (which drives `pc`) and an external program loader, such as a UART receiver or test harness.

## Interface
- `ADDR_W`, default 8: width of `pc` and of the word address.
- `DATA_W`, default 16: instruction width. Must be a multiple of 8; BPW = DATA_W/8 bytes per word.
- `DEPTH`, default 256: number of words. Must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- `clk` in, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` in, 1 bit: reset, asynchronous and active-low.
- `pc` in, ADDR_W bits: fetch address.
- `rd_en` in, 1 bit: fetch request, sampled with `pc`.
- `op` out, DATA_W bits: registered instruction.
- `op_valid` out, 1 bit: `op` is valid this cycle.
- `ld_start` in, 1 bit: single-cycle pulse. Enters LOAD from RUN, or ends a load in progress.
- `ld_data` in, 8 bits: program byte.
- `ld_valid` in, 1 bit: `ld_data` is valid.
- `ld_ready` out, 1 bit: the block accepts a byte this cycle.
- `ld_busy` out, 1 bit: the FSM is in LOAD.
- `ld_done` out, 1 bit: at least one load has completed since reset.
- `ld_count` out, ADDR_W+1 bits: number of words written by the most recent load.
- `parity_err` out, 1 bit: read parity mismatch. Tied 0 unless `IMEM_PARITY_EN` is defined.

## Operation
- FSM states and transitions:
  - RUN → LOAD on `ld_start`.
  - LOAD → RUN on `ld_start`, or after word DEPTH-1 has been written.
- Reset values:
  - FSM = RUN.
  - `op` = 0, `op_valid` = 0.
  - `ld_ready` = 0, `ld_busy` = 0, `ld_done` = 0, `ld_count` = 0.
  - `parity_err` = 0.
  - Internal byte counter = 0, word address = 0, assembly register = 0.
  - RAM contents are not reset and are undefined until loaded.
- Entering LOAD:
  - Word address, byte counter and `ld_count` clear to 0.
  - `ld_busy` = 1, `ld_ready` = 1.
- Byte assembly:
  - A byte is accepted on `ld_valid && ld_ready`.
  - Bytes arrive big-endian: the first byte of a word lands in bits [DATA_W-1:DATA_W-8]. This matches the opcode-in-MSBs instruction layout.
  - `ld_valid` without `ld_ready` is ignored.
- Word write:
  - On acceptance of byte BPW-1, the full word is written to RAM[word address] at that same edge.
  - Word address and `ld_count` then increment, and the byte counter returns to 0.
- End of load:
  - After the word at address DEPTH-1 is written, the FSM returns to RUN at that edge. No wrap-around and no further writes occur.
  - If `ld_start` arrives during LOAD, the FSM returns to RUN. A partially assembled word is discarded, and a byte presented in the same cycle is not accepted (`ld_ready` is deasserted by `ld_start`).
  - On either exit, `ld_done` is set to 1 and `ld_count` holds until the next load.
- Fetch in RUN:
  - `rd_en` registers `pc`.
  - If `pc` < DEPTH: next cycle `op` = RAM[pc] and `op_valid` = 1.
  - If `pc` ≥ DEPTH: `op` = 0 and `op_valid` = 1.
  - Without `rd_en`: `op_valid` = 0 and `op` holds its value.
- Fetch in LOAD: `rd_en` is ignored, `op_valid` = 0 and `op` holds.
- Simultaneous `rd_en` and `ld_start` in RUN: the load wins, the fetch is dropped, and `op_valid` = 0 next cycle.
- Reset asserted mid-load: all registers return to reset values and `ld_done` = 0. RAM holds partial, undefined content; software reloads it.
- Fetch before the first load: the cycle behaviour is the same, but the returned data is undefined.

## Timing
- Read latency is 1 cycle: `pc`/`rd_en` sampled at edge N give `op`/`op_valid` after edge N.
- Back-to-back reads sustain 1 instruction per cycle.
- Load throughput is 1 byte per cycle. `ld_ready` stays 1 throughout LOAD, so one word takes BPW cycles.
- A word written at edge N is readable by a fetch sampled at edge N+1 or later, once the FSM is back in RUN.
- `ld_busy` and `ld_ready` change at the same edge as the state register.

## Configuration
- Macro `IMEM_PARITY_EN`:
  - Defined:
    - Each RAM word stores an extra even-parity bit, computed over the assembled word at write.
    - On read, parity is recomputed. `parity_err` = 1 for exactly the cycle in which `op_valid` = 1 and the stored and recomputed parity differ.
    - Out-of-range reads never flag an error.
  - Not defined:
    - RAM is DATA_W wide and no parity logic exists.
    - `parity_err` is constant 0.

## Test plan
- Full load: with default parameters, load 512 bytes (word k = k*257 mod 65536).
  - `ld_busy` drops after the 512th byte; `ld_done` = 1; `ld_count` = 256.
  - Reading pc = 0, 1 and 255 gives 0x0000, 0x0101 and 0xFFFF, each with 1-cycle latency.
- Early terminate: `ld_start`, then bytes 0xA1 0xB2 0xC3, then `ld_start`.
  - `ld_count` = 1 and RAM[0] = 0xA1B2.
  - 0xC3 is discarded and RAM[1] is unchanged.
- Handshake gaps: `ld_valid` toggles randomly during the load.
  - The assembled words are identical to a gap-free load.
  - No byte is accepted while `ld_ready` = 0.
- Conflict and range: `rd_en` in the same cycle as `ld_start` gives `op_valid` = 0 next cycle.
  - With DEPTH = 200, reading pc = 250 gives `op` = 0 and `op_valid` = 1.
- Reset mid-load: drop `rst_n` after 3 bytes.
  - All outputs return to reset values immediately (asynchronous) and `ld_done` = 0.
  - A subsequent full load behaves normally.
- Parity (with `IMEM_PARITY_EN`): force-flip one stored bit of RAM[5], then read pc = 5.
  - `parity_err` = 1 for one cycle, aligned with `op_valid`.
  - A read of an unflipped word gives `parity_err` = 0.
